// File: rtl/pool_window_gen_pkg.sv
// Shared lane ordering for 2x2 pooling windows; the max-pool stage unpacks
// windows in this same order.
package pool_window_gen_pkg;
   localparam int LANES   = 4;
   localparam int LANE_TL = 0;
   localparam int LANE_TR = 1;
   localparam int LANE_BL = 2;
   localparam int LANE_BR = 3;

   function automatic int window_w(input int data_w);
      return LANES * data_w;
   endfunction
endpackage

// File: rtl/pool_line_buffer.sv
// One-row pixel store: single write port, two combinational read ports used to
// fetch the TL/TR pair of the even row above.
module pool_line_buffer #(
   parameter int DEPTH  = 16,
   parameter int DATA_W = 8,
   parameter int AW     = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              we_i,
   input  logic [AW-1:0]     waddr_i,
   input  logic [DATA_W-1:0] wdata_i,
   input  logic [AW-1:0]     raddr_lo_i,
   input  logic [AW-1:0]     raddr_hi_i,
   output logic [DATA_W-1:0] rdata_lo_o,
   output logic [DATA_W-1:0] rdata_hi_o
);
   logic [DATA_W-1:0] mem_q [DEPTH];

   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= wdata_i;
   end

   assign rdata_lo_o = mem_q[raddr_lo_i];
   assign rdata_hi_o = mem_q[raddr_hi_i];
endmodule

// File: rtl/pool_window_gen.sv
// Raster pixel stream to non-overlapping 2x2 stride-2 windows; one window per
// odd-row/odd-column pixel, held in a single-entry valid/ready output register.
module pool_window_gen
   import pool_window_gen_pkg::*;
#(
   parameter int IMG_W  = 16,
   parameter int IMG_H  = 16,
   parameter int DATA_W = 8
) (
   input  logic                        clk,
   input  logic                        reset_n,
   input  logic                        s_valid,
   output logic                        s_ready,
   input  logic [DATA_W-1:0]           s_data,
   output logic                        m_valid,
   input  logic                        m_ready,
   output logic [window_w(DATA_W)-1:0] m_window,
   output logic                        m_last
);
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int WW = window_w(DATA_W);
   localparam logic [CW-1:0] COL_MAX   = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_MAX   = RW'(IMG_H - 1);
   localparam logic [CW-1:0] COL_LASTW = CW'(2 * (IMG_W / 2) - 1);
   localparam logic [RW-1:0] ROW_LASTW = RW'(2 * (IMG_H / 2) - 1);
   localparam bit ODD_W = (IMG_W % 2) == 1;
   localparam bit ODD_H = (IMG_H % 2) == 1;

   logic [CW-1:0]     col_q, col_d;
   logic [RW-1:0]     row_q, row_d;
   logic [DATA_W-1:0] bl_q, bl_d;
   logic [WW-1:0]     win_q, win_d;
   logic              vld_q, vld_d;
   logic              last_q, last_d;
   logic              accept, col_wrap, row_wrap, col_tail, row_tail;
   logic              lb_we, bl_we, win_fire;
   logic [DATA_W-1:0] lb_prev, lb_cur;

   assign s_ready  = !vld_q || m_ready;
   assign accept   = s_valid && s_ready;
   assign col_wrap = (col_q == COL_MAX);
   assign row_wrap = (row_q == ROW_MAX);
   // Trailing odd column/row pixels are swallowed without touching the window path.
   assign col_tail = ODD_W && col_wrap;
   assign row_tail = ODD_H && row_wrap;
   assign lb_we    = accept && !row_q[0] && !col_tail && !row_tail;
   assign bl_we    = accept && row_q[0] && !col_q[0] && !col_tail;
   assign win_fire = accept && row_q[0] && col_q[0];

   pool_line_buffer #(
      .DEPTH (IMG_W),
      .DATA_W(DATA_W)
   ) u_lbuf (
      .clk       (clk),
      .we_i      (lb_we),
      .waddr_i   (col_q),
      .wdata_i   (s_data),
      .raddr_lo_i(col_q - CW'(1)),
      .raddr_hi_i(col_q),
      .rdata_lo_o(lb_prev),
      .rdata_hi_o(lb_cur)
   );

   always_comb begin
      col_d  = col_q;
      row_d  = row_q;
      bl_d   = bl_q;
      win_d  = win_q;
      vld_d  = vld_q;
      last_d = last_q;
      if (accept) begin
         col_d = col_wrap ? '0 : col_q + CW'(1);
         if (col_wrap) row_d = row_wrap ? '0 : row_q + RW'(1);
      end
      if (bl_we) bl_d = s_data;
      if (win_fire) begin
         win_d[LANE_TL*DATA_W +: DATA_W] = lb_prev;
         win_d[LANE_TR*DATA_W +: DATA_W] = lb_cur;
         win_d[LANE_BL*DATA_W +: DATA_W] = bl_q;
         win_d[LANE_BR*DATA_W +: DATA_W] = s_data;
         vld_d  = 1'b1;
         last_d = (row_q == ROW_LASTW) && (col_q == COL_LASTW);
      end else if (m_ready) begin
         vld_d  = 1'b0;
         last_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         col_q  <= '0;
         row_q  <= '0;
         win_q  <= '0;
         vld_q  <= 1'b0;
         last_q <= 1'b0;
      end else begin
         col_q  <= col_d;
         row_q  <= row_d;
         win_q  <= win_d;
         vld_q  <= vld_d;
         last_q <= last_d;
      end
   end

   always_ff @(posedge clk) begin
      bl_q <= bl_d;
   end

   assign m_valid  = vld_q;
   assign m_window = win_q;
   assign m_last   = last_q;
endmodule

// File: tb/tb_pool_window_gen.sv
// Bench for pool_window_gen: 4x4, 5x5 and 16x16 instances share stimulus; the
// selected instance is scored against a 2x2-block reference built from the pixel list.
module tb_pool_window_gen;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset_n, s_valid, m_ready;
   logic [7:0] s_data;
   logic       sr4, mv4, ml4, sr5, mv5, ml5, sr16, mv16, ml16;
   logic [31:0] mw4, mw5, mw16;

   pool_window_gen #(.IMG_W(4), .IMG_H(4), .DATA_W(8)) u_dut4 (
      .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(sr4), .s_data(s_data),
      .m_valid(mv4), .m_ready(m_ready), .m_window(mw4), .m_last(ml4));
   pool_window_gen #(.IMG_W(5), .IMG_H(5), .DATA_W(8)) u_dut5 (
      .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(sr5), .s_data(s_data),
      .m_valid(mv5), .m_ready(m_ready), .m_window(mw5), .m_last(ml5));
   pool_window_gen #(.IMG_W(16), .IMG_H(16), .DATA_W(8)) u_dut16 (
      .clk(clk), .reset_n(reset_n), .s_valid(s_valid), .s_ready(sr16), .s_data(s_data),
      .m_valid(mv16), .m_ready(m_ready), .m_window(mw16), .m_last(ml16));

   int          sel;
   logic        sr, mv, ml;
   logic [31:0] mw;
   always_comb begin
      sr = sr4; mv = mv4; ml = ml4; mw = mw4;
      case (sel)
         5:  begin sr = sr5;  mv = mv5;  ml = ml5;  mw = mw5;  end
         16: begin sr = sr16; mv = mv16; ml = ml16; mw = mw16; end
         default: ;
      endcase
   end

   int n_chk = 0;
   int n_fail = 0;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   logic [7:0]  stim[$];
   logic [32:0] exp_q[$];
   logic [31:0] got_q[$];
   int          exp_rd, hs_cnt, last_cnt, acc_cnt, stall_cnt, rdy_mode;
   bit          mon_en = 1'b0;
   logic        p_mv, p_ml, p_hs, p_acc, p_stall;
   logic [31:0] p_mw;
   logic [7:0]  p_data;

   function automatic logic [31:0] got(input int i);
      return (got_q.size() > i) ? got_q[i] : 32'hxxxxxxxx;
   endfunction

   // Downstream ready: 0 always, 1 random, 2 five-cycle stall on first window, 3 never.
   always @(posedge clk) begin
      #1;
      case (rdy_mode)
         0: m_ready = 1'b1;
         1: m_ready = 1'($urandom_range(0, 1));
         2: if (hs_cnt == 0 && mv && stall_cnt < 5) begin
               m_ready = 1'b0;
               stall_cnt++;
            end else m_ready = 1'b1;
         default: m_ready = 1'b0;
      endcase
      if (rdy_mode != 2) stall_cnt = 0;
   end

   always @(negedge clk) begin
      if (!mon_en) begin
         exp_rd = 0; hs_cnt = 0; last_cnt = 0; acc_cnt = 0; got_q.delete();
         p_mv = 0; p_ml = 0; p_hs = 0; p_acc = 0; p_stall = 0; p_mw = 0; p_data = 0;
      end else begin
         chk("s_ready_rule", sr, !mv || m_ready);
         if (p_stall) begin
            chk("hold_valid", mv, 1'b1);
            chk("hold_window", mw, p_mw);
            chk("hold_last", ml, p_ml);
         end else if (mv && (!p_mv || p_hs)) begin
            chk("latency_accept", p_acc, 1'b1);
            chk("latency_br_pixel", mw[31:24], p_data);
         end
         if (mv && m_ready) begin
            if (exp_rd < exp_q.size()) begin
               chk("window", mw, exp_q[exp_rd][31:0]);
               chk("last", ml, exp_q[exp_rd][32]);
               exp_rd++;
            end else chk("extra_window", hs_cnt + 1, exp_q.size());
            got_q.push_back(mw);
            hs_cnt++;
            if (ml) last_cnt++;
         end
         p_acc = s_valid && sr;
         if (p_acc) begin
            acc_cnt++;
            p_data = s_data;
         end
         p_mv = mv; p_hs = mv && m_ready; p_stall = mv && !m_ready; p_mw = mw; p_ml = ml;
      end
   end

   task automatic do_reset();
      mon_en = 1'b0;
      s_valid = 1'b0;
      exp_q.delete();
      @(posedge clk); #1 reset_n = 1'b0;
      @(posedge clk); #1 reset_n = 1'b1;
      @(negedge clk); #1 mon_en = 1'b1;
   endtask

   task automatic fill_seq(input int n, input int first);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(8'(first + i));
   endtask

   task automatic fill_rand(input int n);
      stim.delete();
      for (int i = 0; i < n; i++) stim.push_back(8'($urandom));
   endtask

   // Reference: every full 2x2 block of each frame, raster order, last on the final block.
   task automatic model(input int w, input int h, input int nf);
      int b;
      for (int f = 0; f < nf; f++)
         for (int r = 0; r < h / 2; r++)
            for (int c = 0; c < w / 2; c++) begin
               b = f * w * h + 2 * r * w + 2 * c;
               exp_q.push_back({(r == h / 2 - 1) && (c == w / 2 - 1),
                                stim[b + w + 1], stim[b + w], stim[b + 1], stim[b]});
            end
   endtask

   task automatic drive(input bit gaps);
      int  t;
      bit  took;
      @(posedge clk); #1;
      for (int i = 0; i < stim.size(); i++) begin
         if (gaps) begin
            s_valid = 1'b0;
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
         end
         s_valid = 1'b1;
         s_data  = stim[i];
         t = 0; took = 1'b0;
         while (!took && t < 200) begin
            @(negedge clk); took = sr;
            @(posedge clk); #1;
            t++;
         end
         if (!took) chk("accept_timeout", t, 0);
      end
      s_valid = 1'b0;
   endtask

   task automatic wait_drain();
      int t = 0;
      while ((exp_rd < exp_q.size() || mv) && t < 500) begin
         @(posedge clk); #1;
         t++;
      end
      if (t >= 500) chk("drain_timeout", exp_rd, exp_q.size());
      @(posedge clk); #3;
   endtask

   task automatic check_4x4(input string tag);
      chk({tag, "_windows"}, hs_cnt, 4);
      chk({tag, "_last_count"}, last_cnt, 1);
      chk({tag, "_accepted"}, acc_cnt, 16);
      chk({tag, "_win0"}, got(0), 32'h05040100);
      chk({tag, "_win1"}, got(1), 32'h07060302);
      chk({tag, "_win2"}, got(2), 32'h0D0C0908);
      chk({tag, "_win3"}, got(3), 32'h0F0E0B0A);
   endtask

   initial begin
      reset_n = 1'b0; s_valid = 1'b0; s_data = '0; sel = 4; rdy_mode = 0;

      do_reset();
      chk("reset_m_valid", mv, 1'b0);
      chk("reset_m_last", ml, 1'b0);
      chk("reset_m_window", mw, 32'h0);
      chk("reset_s_ready", sr, 1'b1);

      fill_seq(16, 0); model(4, 4, 1); drive(1'b0); wait_drain();
      check_4x4("basic");

      rdy_mode = 2;
      do_reset();
      fill_seq(16, 0); model(4, 4, 1); drive(1'b0); wait_drain();
      check_4x4("stall");
      chk("stall_cycles", stall_cnt, 5);
      rdy_mode = 0;

      do_reset();
      fill_seq(32, 0); model(4, 4, 2); drive(1'b0); wait_drain();
      chk("b2b_windows", hs_cnt, 8);
      chk("b2b_last_count", last_cnt, 2);
      chk("b2b_frame2_win0", got(4), 32'h15141110);

      sel = 5;
      do_reset();
      fill_seq(25, 0); model(5, 5, 1); drive(1'b0); wait_drain();
      chk("odd_accepted", acc_cnt, 25);
      chk("odd_windows", hs_cnt, 4);
      chk("odd_last_count", last_cnt, 1);
      chk("odd_win0", got(0), 32'h06050100);
      chk("odd_win1", got(1), 32'h08070302);
      chk("odd_win2", got(2), 32'h100F0B0A);
      chk("odd_win3", got(3), 32'h12110D0C);

      sel = 4; rdy_mode = 3;
      do_reset();
      fill_seq(6, 0); drive(1'b0);
      @(posedge clk); #1;
      chk("midrst_pending", mv, 1'b1);
      chk("midrst_accepted", acc_cnt, 6);
      do_reset();
      chk("midrst_valid_cleared", mv, 1'b0);
      chk("midrst_s_ready", sr, 1'b1);
      rdy_mode = 0;
      fill_seq(16, 0); model(4, 4, 1); drive(1'b0); wait_drain();
      check_4x4("after_rst");

      sel = 16; rdy_mode = 1;
      do_reset();
      fill_rand(512); model(16, 16, 2); drive(1'b1); wait_drain();
      chk("rand_windows", hs_cnt, 128);
      chk("rand_last_count", last_cnt, 2);
      chk("rand_accepted", acc_cnt, 512);
      chk("rand_all_scored", exp_rd, 128);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: time limit reached, got %0d checks, expected test completion", n_chk);
      $fatal(1);
   end
endmodule
